// File: rtl/reg_file_mwnr.sv
// Multi-write / multi-read register file with per-byte strobes, per-register valid bits and a synchronous clear.
// Define REG_FILE_WR_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mwnr #(
    parameter int DataWidth    = 32,
    parameter int NumRegs      = 32,
    parameter int NumWrPorts   = 2,
    parameter int NumRdPorts   = 2,
    parameter int NumRegsWidth = $clog2(NumRegs),
    parameter int StrbWidth    = DataWidth / 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     clr_i,
    input  logic [NumWrPorts-1:0]                    wr_en_i,
    input  logic [NumWrPorts-1:0][NumRegsWidth-1:0]  wr_addr_i,
    input  logic [NumWrPorts-1:0][DataWidth-1:0]     wr_data_i,
    input  logic [NumWrPorts-1:0][StrbWidth-1:0]     wr_strb_i,
    input  logic [NumRdPorts-1:0][NumRegsWidth-1:0]  rd_addr_i,
    output logic [NumRdPorts-1:0][DataWidth-1:0]     rd_data_o,
    output logic [NumRdPorts-1:0]                    rd_valid_o,
    output logic [NumRegs-1:0]                       valid_o
);

    localparam bit AllAddrValid = (NumRegs == (1 << NumRegsWidth));

    logic [DataWidth-1:0]  regs_q [NumRegs];
    logic [DataWidth-1:0]  regs_d [NumRegs];
    logic [NumRegs-1:0]    valid_q;
    logic [NumRegs-1:0]    valid_d;
    logic [NumWrPorts-1:0] wr_ok;
    logic [NumRdPorts-1:0] rd_ok;

    // Address range checks only exist when NumRegs leaves unused codes at the top.
    if (AllAddrValid) begin : g_full_range
        assign wr_ok = '1;
        assign rd_ok = '1;
    end else begin : g_partial_range
        localparam logic [NumRegsWidth-1:0] LastReg = NumRegsWidth'(NumRegs - 1);
        for (genvar p = 0; p < NumWrPorts; p++) begin : g_wr_ok
            assign wr_ok[p] = (wr_addr_i[p] <= LastReg);
        end
        for (genvar q = 0; q < NumRdPorts; q++) begin : g_rd_ok
            assign rd_ok[q] = (rd_addr_i[q] <= LastReg);
        end
    end

    // Ports are applied in ascending order, so for each byte the highest enabled port wins.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        regs_d  = regs_q;
        valid_d = valid_q;
        if (clr_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_d[i] = '0;
            end
            valid_d = '0;
        end else begin
            for (int p = 0; p < NumWrPorts; p++) begin
                if (wr_en_i[p] && wr_ok[p]) begin
                    valid_d[wr_addr_i[p]] = 1'b1;
                    for (int b = 0; b < StrbWidth; b++) begin
                        if (wr_strb_i[p][b]) begin
                            regs_d[wr_addr_i[p]][8*b +: 8] = wr_data_i[p][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the array is reset explicitly because reads must return zero straight out of reset.
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all clocked state.
            regs_q  <= regs_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int q = 0; q < NumRdPorts; q++) begin
            rd_data_o[q]  = '0;
            rd_valid_o[q] = 1'b0;
            if (rd_ok[q]) begin
                rd_data_o[q]  = regs_q[rd_addr_i[q]];
                rd_valid_o[q] = valid_q[rd_addr_i[q]];
            end
`ifdef REG_FILE_WR_BYPASS_EN
            // Forwarding mirrors the write priority; a clear shows stored state instead.
            if (!clr_i && rd_ok[q]) begin
                for (int p = 0; p < NumWrPorts; p++) begin
                    if (wr_en_i[p] && wr_ok[p] && (wr_addr_i[p] == rd_addr_i[q])) begin
                        rd_valid_o[q] = 1'b1;
                        for (int b = 0; b < StrbWidth; b++) begin
                            if (wr_strb_i[p][b]) begin
                                rd_data_o[q][8*b +: 8] = wr_data_i[p][8*b +: 8];
                            end
                        end
                    end
                end
            end
`endif
        end
    end

    assign valid_o = valid_q;

endmodule

// File: tb/tb_reg_file_mwnr.sv
// Self-checking bench for reg_file_mwnr: directed vector table, corner-case sequences and a scoreboard run
// on a 32-register and a 5-register instance.
module tb_reg_file_mwnr;

`ifdef REG_FILE_WR_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             a_clr;
    logic [1:0]       a_wr_en;
    logic [1:0][4:0]  a_wr_addr;
    logic [1:0][31:0] a_wr_data;
    logic [1:0][3:0]  a_wr_strb;
    logic [1:0][4:0]  a_rd_addr;
    logic [1:0][31:0] a_rd_data;
    logic [1:0]       a_rd_valid;
    logic [31:0]      a_valid;

    logic             b_clr;
    logic [1:0]       b_wr_en;
    logic [1:0][2:0]  b_wr_addr;
    logic [1:0][31:0] b_wr_data;
    logic [1:0][3:0]  b_wr_strb;
    logic [1:0][2:0]  b_rd_addr;
    logic [1:0][31:0] b_rd_data;
    logic [1:0]       b_rd_valid;
    logic [4:0]       b_valid;

    reg_file_mwnr #(.NumRegs(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(a_clr),
        .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data), .wr_strb_i(a_wr_strb),
        .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .valid_o(a_valid)
    );

    reg_file_mwnr #(.NumRegs(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .clr_i(b_clr),
        .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data), .wr_strb_i(b_wr_strb),
        .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .valid_o(b_valid)
    );

    typedef struct {
        bit             clr;
        bit [1:0]       en;
        bit [1:0][7:0]  addr;
        bit [1:0][31:0] data;
        bit [1:0][3:0]  strb;
        bit [1:0][7:0]  raddr;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] exp0;
        logic        expv0;
        logic [31:0] exp1;
        logic        expv1;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl  [2][32];
    bit          mval [2][32];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit clr, bit [1:0] en,
                                int a0, bit [31:0] d0, bit [3:0] s0,
                                int a1, bit [31:0] d1, bit [3:0] s1,
                                int r0, int r1,
                                bit [31:0] e0, bit v0, bit [31:0] e1, bit v1);
        vec_t v;
        v.s.clr      = clr;
        v.s.en       = en;
        v.s.addr[0]  = 8'(a0);
        v.s.addr[1]  = 8'(a1);
        v.s.data[0]  = d0;
        v.s.data[1]  = d1;
        v.s.strb[0]  = s0;
        v.s.strb[1]  = s1;
        v.s.raddr[0] = 8'(r0);
        v.s.raddr[1] = 8'(r1);
        v.exp0       = e0;
        v.expv0      = v0;
        v.exp1       = e1;
        v.expv1      = v1;
        return v;
    endfunction

    task automatic drive_a(input stim_t s);
        a_clr   = s.clr;
        a_wr_en = s.en;
        for (int p = 0; p < 2; p++) begin
            a_wr_addr[p] = s.addr[p][4:0];
            a_wr_data[p] = s.data[p];
            a_wr_strb[p] = s.strb[p];
            a_rd_addr[p] = s.raddr[p][4:0];
        end
    endtask

    task automatic drive_b(input stim_t s);
        b_clr   = s.clr;
        b_wr_en = s.en;
        for (int p = 0; p < 2; p++) begin
            b_wr_addr[p] = s.addr[p][2:0];
            b_wr_data[p] = s.data[p];
            b_wr_strb[p] = s.strb[p];
            b_rd_addr[p] = s.raddr[p][2:0];
        end
    endtask

    task automatic idle_writes();
        a_clr   = 1'b0;
        a_wr_en = '0;
        b_clr   = 1'b0;
        b_wr_en = '0;
    endtask

    function automatic int nregs_of(int d);
        return (d == 0) ? 32 : 5;
    endfunction

    // Scoreboard: per byte, search ports from the highest down for the first enabled writer.
    function automatic logic [31:0] exp_data(int d, stim_t s, int q);
        int          a;
        logic [31:0] r;
        a = int'(s.raddr[q]);
        if (a >= nregs_of(d)) return '0;
        r = mdl[d][a];
        if (Bypass && !s.clr) begin
            for (int b = 0; b < 4; b++) begin
                for (int p = 1; p >= 0; p--) begin
                    if (s.en[p] && int'(s.addr[p]) == a && s.strb[p][b]) begin
                        r[8*b +: 8] = s.data[p][8*b +: 8];
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic exp_valid(int d, stim_t s, int q);
        int   a;
        logic v;
        a = int'(s.raddr[q]);
        if (a >= nregs_of(d)) return 1'b0;
        v = mval[d][a];
        if (Bypass && !s.clr) begin
            for (int p = 0; p < 2; p++) begin
                if (s.en[p] && int'(s.addr[p]) == a) v = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_vmap(int d);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < nregs_of(d); i++) m[i] = mval[d][i];
        return m;
    endfunction

    task automatic commit(input int d, input stim_t s);
        if (s.clr) begin
            for (int i = 0; i < 32; i++) begin
                mdl[d][i]  = '0;
                mval[d][i] = 1'b0;
            end
        end else begin
            for (int a = 0; a < nregs_of(d); a++) begin
                for (int p = 0; p < 2; p++) begin
                    if (s.en[p] && int'(s.addr[p]) == a) mval[d][a] = 1'b1;
                end
                for (int b = 0; b < 4; b++) begin
                    for (int p = 1; p >= 0; p--) begin
                        if (s.en[p] && int'(s.addr[p]) == a && s.strb[p][b]) begin
                            mdl[d][a][8*b +: 8] = s.data[p][8*b +: 8];
                            break;
                        end
                    end
                end
            end
        end
    endtask

    function automatic stim_t rnd_stim(int d);
        stim_t       s;
        int unsigned top;
        top   = (d == 0) ? 31 : 7;
        s.clr = ($urandom_range(0, 63) == 0);
        s.en  = 2'($urandom_range(0, 3));
        for (int p = 0; p < 2; p++) begin
            s.addr[p]  = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, top));
            s.data[p]  = $urandom;
            s.strb[p]  = 4'($urandom_range(0, 15));
            s.raddr[p] = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, top));
        end
        return s;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        vec_t  vecs [8];
        stim_t sa;
        stim_t sb;

        vecs[0] = mk(0, 2'b01, 3, 32'h11223344, 4'hF, 0, 32'h0, 4'h0, 3, 3,
                     32'h11223344, 1, 32'h11223344, 1);
        vecs[1] = mk(0, 2'b01, 3, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 4'h0, 3, 3,
                     32'h11BB33DD, 1, 32'h11BB33DD, 1);
        vecs[2] = mk(0, 2'b11, 7, 32'h000000FF, 4'hF, 7, 32'h12345600, 4'b1110, 7, 3,
                     32'h123456FF, 1, 32'h11BB33DD, 1);
        vecs[3] = mk(0, 2'b11, 7, 32'h000000FF, 4'hF, 7, 32'h12345600, 4'b0000, 7, 7,
                     32'h000000FF, 1, 32'h000000FF, 1);
        vecs[4] = mk(0, 2'b10, 0, 32'h0, 4'h0, 10, 32'hFFFFFFFF, 4'b0000, 10, 7,
                     32'h00000000, 1, 32'h000000FF, 1);
        vecs[5] = mk(0, 2'b00, 0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 11, 3,
                     32'h00000000, 0, 32'h11BB33DD, 1);
        vecs[6] = mk(0, 2'b11, 5, 32'hDEADBEEF, 4'hF, 6, 32'h00C0FFEE, 4'b0011, 5, 6,
                     32'hDEADBEEF, 1, 32'h0000FFEE, 1);
        vecs[7] = mk(1, 2'b01, 5, 32'hDEADBEEF, 4'hF, 0, 32'h0, 4'h0, 5, 3,
                     32'h00000000, 0, 32'h00000000, 0);

        idle_writes();
        a_wr_addr = '0; a_wr_data = '0; a_wr_strb = '0; a_rd_addr = '0;
        b_wr_addr = '0; b_wr_data = '0; b_wr_strb = '0; b_rd_addr = '0;

        // Reset state, before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset a_valid_o", a_valid, 32'h0);
        check("reset a_rd_data0", a_rd_data[0], 32'h0);
        check("reset a_rd_valid", 32'(a_rd_valid), 32'h0);
        check("reset b_valid_o", 32'(b_valid), 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Asynchronous reset mid-cycle, then a write held across an edge under reset.
        a_wr_en = 2'b01; a_wr_addr[0] = 5'd5; a_wr_data[0] = 32'hDEADBEEF; a_wr_strb[0] = 4'hF;
        a_rd_addr[0] = 5'd5; a_rd_addr[1] = 5'd5;
        tick();
        idle_writes();
        #2;
        check("pre-reset rd_data0", a_rd_data[0], 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("async reset rd_data0", a_rd_data[0], 32'h0);
        check("async reset valid_o", a_valid, 32'h0);
        check("async reset rd_valid0", 32'(a_rd_valid[0]), 32'h0);
        a_wr_en = 2'b01; a_wr_data[0] = 32'h12345678;
        @(posedge clk);
        #1 idle_writes();
        #2 rst = 1'b0;
        #1;
        check("write under reset dropped", a_rd_data[0], 32'h0);
        check("write under reset valid_o", a_valid, 32'h0);
        tick();

        // Directed vectors: apply, let one edge commit, then read back stored state.
        for (int i = 0; i < 8; i++) begin
            drive_a(vecs[i].s);
            tick();
            idle_writes();
            #4;
            check($sformatf("vec%0d rd_data0", i), a_rd_data[0], vecs[i].exp0);
            check($sformatf("vec%0d rd_valid0", i), 32'(a_rd_valid[0]), 32'(vecs[i].expv0));
            check($sformatf("vec%0d rd_data1", i), a_rd_data[1], vecs[i].exp1);
            check($sformatf("vec%0d rd_valid1", i), 32'(a_rd_valid[1]), 32'(vecs[i].expv1));
        end
        check("after clear valid_o", a_valid, 32'h0);
        tick();

        // Load reg[i] = 3*i through both ports, then read from both ports at once.
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 2'b11;
            a_wr_addr[0] = 5'(i);      a_wr_data[0] = 32'(3 * i);        a_wr_strb[0] = 4'hF;
            a_wr_addr[1] = 5'(i + 16); a_wr_data[1] = 32'(3 * (i + 16)); a_wr_strb[1] = 4'hF;
            tick();
        end
        idle_writes();
        a_rd_addr[0] = 5'd31; a_rd_addr[1] = 5'd31;
        #4;
        check("multi-read 31 port0", a_rd_data[0], 32'd93);
        check("multi-read 31 port1", a_rd_data[1], 32'd93);
        check("multi-read valid_o", a_valid, 32'hFFFFFFFF);
        a_rd_addr[0] = 5'd0; a_rd_addr[1] = 5'd2;
        #1;
        check("multi-read 0 port0", a_rd_data[0], 32'd0);
        check("multi-read 2 port1", a_rd_data[1], 32'd6);
        check("multi-read rd_valid", 32'(a_rd_valid), 32'h3);
        tick();

        // Same-cycle write and read of reg 9 after a clear.
        a_clr = 1'b1;
        tick();
        idle_writes();
        a_wr_en = 2'b01; a_wr_addr[0] = 5'd9; a_wr_data[0] = 32'hCAFEF00D; a_wr_strb[0] = 4'hF;
        a_rd_addr[0] = 5'd9; a_rd_addr[1] = 5'd9;
        #4;
        check("bypass same-cycle rd_data0", a_rd_data[0], Bypass ? 32'hCAFEF00D : 32'h0);
        check("bypass same-cycle rd_data1", a_rd_data[1], Bypass ? 32'hCAFEF00D : 32'h0);
        check("bypass same-cycle rd_valid0", 32'(a_rd_valid[0]), Bypass ? 32'h1 : 32'h0);
        tick();
        idle_writes();
        #4;
        check("bypass next-cycle rd_data0", a_rd_data[0], 32'hCAFEF00D);
        check("bypass next-cycle rd_valid0", 32'(a_rd_valid[0]), 32'h1);
        a_clr = 1'b1; a_wr_en = 2'b01; a_wr_data[0] = 32'h11111111;
        #1;
        check("clear suppresses forward data", a_rd_data[0], 32'hCAFEF00D);
        check("clear suppresses forward valid", 32'(a_rd_valid[0]), 32'h1);
        tick();
        idle_writes();
        #4;
        check("clear beats write data", a_rd_data[0], 32'h0);
        check("clear beats write valid", 32'(a_rd_valid[0]), 32'h0);

        // Out-of-range addresses on the 5-register instance.
        b_wr_en = 2'b11;
        b_wr_addr[0] = 3'd4; b_wr_data[0] = 32'h01020304; b_wr_strb[0] = 4'hF;
        b_wr_addr[1] = 3'd6; b_wr_data[1] = 32'hFFFFFFFF; b_wr_strb[1] = 4'hF;
        b_rd_addr[0] = 3'd4; b_rd_addr[1] = 3'd6;
        tick();
        idle_writes();
        #4;
        check("oor last reg data", b_rd_data[0], 32'h01020304);
        check("oor last reg valid", 32'(b_rd_valid[0]), 32'h1);
        check("oor read data", b_rd_data[1], 32'h0);
        check("oor read valid", 32'(b_rd_valid[1]), 32'h0);
        check("oor valid_o", 32'(b_valid), 32'h10);
        b_wr_en = 2'b10; b_wr_addr[1] = 3'd7; b_rd_addr[1] = 3'd7;
        #1;
        check("oor same-cycle data", b_rd_data[1], 32'h0);
        check("oor same-cycle valid", 32'(b_rd_valid[1]), 32'h0);
        tick();
        idle_writes();

        // Scoreboard run on both instances from a fresh reset.
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                mdl[d][i]  = '0;
                mval[d][i] = 1'b0;
            end
        end
        tick();
        for (int c = 0; c < 10000; c++) begin
            sa = rnd_stim(0);
            sb = rnd_stim(1);
            drive_a(sa);
            drive_b(sb);
            #4;
            for (int q = 0; q < 2; q++) begin
                check($sformatf("rand32 c%0d rd_data%0d", c, q), a_rd_data[q], exp_data(0, sa, q));
                check($sformatf("rand32 c%0d rd_valid%0d", c, q), 32'(a_rd_valid[q]), 32'(exp_valid(0, sa, q)));
                check($sformatf("rand5 c%0d rd_data%0d", c, q), b_rd_data[q], exp_data(1, sb, q));
                check($sformatf("rand5 c%0d rd_valid%0d", c, q), 32'(b_rd_valid[q]), 32'(exp_valid(1, sb, q)));
            end
            check($sformatf("rand32 c%0d valid_o", c), a_valid, exp_vmap(0));
            check($sformatf("rand5 c%0d valid_o", c), 32'(b_valid), exp_vmap(1));
            @(posedge clk);
            commit(0, sa);
            commit(1, sb);
            #1;
        end
        idle_writes();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mwnr.md
Name: reg_file_mwnr

Overview:
- Parametrised multi-port register file; successor of the single-write/single-read register set.
- Generalised to NumWrPorts write ports and NumRdPorts read ports, with per-byte write strobes, per-register valid bits and a synchronous global clear.
- Serves as general-purpose storage for item memories, query buffers and scratch registers in the HDC datapath.

Parameters:
- DataWidth, 32, register width in bits; must be a multiple of 8.
- NumRegs, 32, number of registers; must be ≥ 2.
- NumWrPorts, 2, number of write ports; must be ≥ 1.
- NumRdPorts, 2, number of read ports; must be ≥ 1.
- NumRegsWidth, $clog2(NumRegs), derived; do not override.
- StrbWidth, DataWidth/8, derived; do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- clr_i  in  1  synchronous clear of all data and valid bits.
- wr_en_i  in  NumWrPorts  per-port write enable.
- wr_addr_i  in  NumWrPorts x NumRegsWidth  per-port write address.
- wr_data_i  in  NumWrPorts x DataWidth  per-port write data.
- wr_strb_i  in  NumWrPorts x StrbWidth  per-port byte strobes.
- rd_addr_i  in  NumRdPorts x NumRegsWidth  per-port read address.
- rd_data_o  out  NumRdPorts x DataWidth  per-port read data.
- rd_valid_o  out  NumRdPorts  valid bit of the addressed register.
- valid_o  out  NumRegs  valid bitmap of all registers.

Behaviour:
- Reset, asynchronous on rst_i=1:
  - All registers go to 0.
  - All valid bits go to 0.
  - rd_data_o=0, rd_valid_o=0, valid_o=0 immediately, with no clock required.
  - Reset asserted mid-write discards that write.
- Clear:
  - clr_i=1 at a rising edge zeros all data and valid bits.
  - Clear has priority over every write in the same cycle.
- Write:
  - Port p writes when wr_en_i[p]=1 and clr_i=0.
  - Byte b of reg[wr_addr_i[p]] takes wr_data_i[p][8b+7:8b] where wr_strb_i[p][b]=1; other bytes hold.
  - The addressed register's valid bit is set to 1 if wr_en_i[p]=1, even when wr_strb_i[p]=0.
  - Write latency is one cycle: data is visible on the read ports after the edge.
- Write collision (two or more ports, same address, same cycle):
  - Resolved per byte.
  - The highest-numbered enabled port with its strobe set for that byte wins.
  - Non-colliding bytes from lower ports still commit.
- Out-of-range address (addr ≥ NumRegs when NumRegs is not a power of two):
  - A write is dropped; no state changes.
  - A read returns rd_data_o=0 and rd_valid_o=0.
- Read:
  - Combinational: rd_data_o[q]=reg[rd_addr_i[q]] and rd_valid_o[q]=valid[rd_addr_i[q]].
  - Zero-cycle read latency.
  - Any number of read ports may address the same register.
- Idle registers hold their value; there is no write-back on idle.
- No handshake, no stall: writes are always accepted.

Optional Feature:
- Macro: REG_FILE_WR_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data combinationally.
  - For each byte, if any enabled write port targets rd_addr_i[q] with that strobe set, rd_data_o shows the winning write byte (same priority as collision resolution); otherwise it shows the stored byte.
  - rd_valid_o[q]=1 if any enabled write port targets rd_addr_i[q].
  - clr_i=1 suppresses forwarding: rd_data_o and rd_valid_o show stored values.
- Undefined:
  - Reads return only stored state; same-cycle writes appear the next cycle.
- Stored state is identical in both builds.

Test Plan:
- Reset/clear:
  - Write 0xDEADBEEF to reg 5, then pulse rst_i mid-cycle → rd_data_o=0 and valid_o=0 immediately, before the next edge.
  - Repeat with clr_i=1 together with wr_en_i[0]=1 → reg 5=0, valid_o=0 after the edge.
- Byte strobes:
  - Reg 3 holds 0x11223344; write 0xAABBCCDD with strb=4'b0101 → reads 0x11BB33DD, valid[3]=1.
- Collision:
  - Port0 writes 0x000000FF with strb=4'b1111 and port1 writes 0x12345600 with strb=4'b1110, both to reg 7 → reg 7=0x123456FF.
  - Same test with port1 strb=4'b0000 → reg 7=0x000000FF, valid[7]=1.
- Multi-read:
  - Regs 0..31 loaded with value=index*3.
  - rd_addr=(31,31) → both ports read 93.
  - rd_addr=(0,2) → reads 0 and 6, same cycle.
- Bypass:
  - Reg 9=0x0; in the same cycle write 0xCAFEF00D (strb=4'hF) to reg 9 and read reg 9.
  - With REG_FILE_WR_BYPASS_EN → 0xCAFEF00D, rd_valid_o=1 in that cycle.
  - Without the macro → 0x0 in that cycle, 0xCAFEF00D the next.
- Random:
  - 10k cycles of random writes, strobes, clears and reads against a scoreboard model → zero mismatches for NumRegs ∈ {5, 32}.
